mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL expose: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL expose: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL expose: ex_valid  in  1  EX presents an instruction this cycle.
REQ-004 SHALL expose: ex_ready  out  1  stage accepts an instruction this cycle.
REQ-005 SHALL expose: ex_load  in  1 and ex_store  in  1  memory operation kind; both 0 = non-memory op.
REQ-006 SHALL expose: ex_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL expose: ex_addr  in  32  effective address, which is also the ALU result for non-memory ops.
REQ-008 SHALL expose: ex_store_data  in  32  store source data.
REQ-009 SHALL expose: ex_rd  in  5  and ex_rd_we  in  1  destination register and write request.
REQ-010 SHALL expose: mem_req  out  1, mem_we  out  1, mem_addr  out  32, mem_wdata  out  8  byte-wide memory request.
REQ-011 SHALL expose: mem_rdata  in  8 and mem_ack  in  1  byte returned / request accepted, sampled on the clock edge.
REQ-012 SHALL expose: wb_enable  out  1, wb_addr  out  5, wb_data  out  32  register-file write port, all registered.
REQ-013 SHALL expose: stall_req  out  1  pipeline stall request, equal to the inverse of ex_ready.

Function
REQ-014 SHALL use FSM states IDLE and ACCESS; ex_ready = (state == IDLE).
REQ-015 IDLE, ex_valid, no load/store: SHALL write wb_enable = ex_rd_we && ex_rd != 0, wb_addr = ex_rd, wb_data = ex_addr on the next edge (latency 1).
REQ-016 IDLE, ex_valid, with load or store: SHALL latch the operands, clear the byte counter, set N = 1/2/4 from funct3[1:0], and enter ACCESS.
REQ-017 ACCESS: SHALL drive mem_req = 1, mem_we = latched store, mem_addr = base + cnt, mem_wdata = store_data byte cnt (little-endian).
REQ-018 On mem_ack in ACCESS with a load: SHALL capture mem_rdata into result byte cnt, then increment cnt.
REQ-019 On mem_ack with cnt == N-1: SHALL return to IDLE and register the writeback on the same edge.
REQ-020 Load writeback: SHALL use wb_enable = rd_we && rd != 0 and wb_data = result sign-extended (B, H) or zero-extended (BU, HU, W) to 32 bits.
REQ-021 Store completion: SHALL set wb_enable = 0.
REQ-022 Without mem_ack in ACCESS: SHALL hold address, data, and counter unchanged, keeping mem_req asserted.
REQ-023 SHALL ignore mem_ack while in IDLE.
REQ-024 With zero wait states, an N-byte access accepted at edge T SHALL produce the writeback at edge T+N+1, with ex_ready high again in that same cycle.
REQ-025 Every cycle that does not register a writeback SHALL deassert wb_enable (a one-cycle pulse per instruction); wb_addr/wb_data SHALL hold their last values.
REQ-026 SHALL handle misaligned addresses byte-serially without exception; address arithmetic SHALL wrap modulo 2^32.
REQ-027 ex_valid with both ex_load and ex_store set SHALL be treated as a load.
REQ-028 An unlisted funct3 on a memory op SHALL be treated as W.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, cnt 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, wb_enable 0, wb_addr 0, wb_data 0.
REQ-030 A reset asserted mid-ACCESS SHALL abort the access with no writeback; no request SHALL be issued until a new instruction is accepted after release.

Structure
REQ-031 The funct3 size encodings, the 32-bit word width, and the 5-bit register-index width SHALL live in the shared cpu_defs package.
REQ-032 Sign/zero extension SHALL be a combinational sub-module, load_extend (inputs: funct3, 32-bit raw; output: 32-bit extended).

Verification
REQ-033 ALU op: ex_valid, rd = 5, ex_addr = 0x1234 -> next cycle wb_enable = 1, wb_addr = 5, wb_data = 0x1234; one cycle later wb_enable = 0.
REQ-034 LB at 0x100, rd = 3, ack every cycle with rdata 0x80 -> exactly one mem_req cycle, then wb_data = 0xFFFFFF80 at T+2.
REQ-035 LW at 0x201 (misaligned), bytes 0x11,0x22,0x33,0x44 with two wait cycles before the 3rd ack -> addresses 0x201..0x204, wb_data = 0x44332211, ex_ready low throughout.
REQ-036 SH at 0x10, data 0xABCD1234 -> mem_we = 1, wdata 0x34 then 0x12; wb_enable stays 0.
REQ-037 LHU to rd = 0 -> access completes, wb_enable = 0.
REQ-038 rst_n pulsed low during the 2nd byte of a LW -> mem_req drops immediately, no wb pulse, and the next ALU op completes with latency 1.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: datapath widths, load/store size encodings,
// memory-stage FSM states and small byte-lane helpers.
package cpu_defs;

   localparam int XLEN  = 32;
   localparam int REG_W = 5;

   // funct3 size/sign encodings for loads and stores
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } mem_state_e;

   // Index of the last byte of an access; unknown encodings behave as a word.
   function automatic logic [1:0] last_byte_idx(input logic [2:0] funct3);
      logic [1:0] idx;
      case (funct3)
         F3_B, F3_BU: idx = 2'd0;
         F3_H, F3_HU: idx = 2'd1;
         default:     idx = 2'd3;
      endcase
      return idx;
   endfunction

   // Little-endian byte lane select.
   function automatic logic [7:0] pick_byte(input logic [XLEN-1:0] word, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of an assembled load value according to funct3.
module load_extend
   import cpu_defs::*;
(
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] raw,
   output logic [XLEN-1:0] extended
);

   // Extend byte/half results; words and unknown encodings pass through.
   always_comb begin
      extended = raw;
      case (funct3)
         F3_B:    extended = {{24{raw[7]}}, raw[7:0]};
         F3_H:    extended = {{16{raw[15]}}, raw[15:0]};
         F3_BU:   extended = {24'd0, raw[7:0]};
         F3_HU:   extended = {16'd0, raw[15:0]};
         default: extended = raw;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: single-cycle ALU writeback, byte-serial load/store
// over an 8-bit memory port, registered register-file write port.
module mem_stage
   import cpu_defs::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ex_valid,
   output logic             ex_ready,
   input  logic             ex_load,
   input  logic             ex_store,
   input  logic [2:0]       ex_funct3,
   input  logic [XLEN-1:0]  ex_addr,
   input  logic [XLEN-1:0]  ex_store_data,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_rd_we,
   output logic             mem_req,
   output logic             mem_we,
   output logic [XLEN-1:0]  mem_addr,
   output logic [7:0]       mem_wdata,
   input  logic [7:0]       mem_rdata,
   input  logic             mem_ack,
   output logic             wb_enable,
   output logic [REG_W-1:0] wb_addr,
   output logic [XLEN-1:0]  wb_data,
   output logic             stall_req
);

   mem_state_e       state_r;
   mem_state_e       state_nxt_s;
   logic [XLEN-1:0]  base_r;
   logic [XLEN-1:0]  store_data_r;
   logic [2:0]       funct3_r;
   logic [REG_W-1:0] rd_r;
   logic             rd_we_r;
   logic             store_r;
   logic [1:0]       last_r;
   logic [1:0]       cnt_r;
   logic [1:0]       cnt_nxt_s;
   logic [XLEN-1:0]  result_r;
   logic [XLEN-1:0]  raw_s;
   logic [XLEN-1:0]  ext_s;
   logic             mem_op_s;
   logic             byte_done_s;
   logic             last_done_s;

   assign mem_op_s  = ex_load | ex_store;
   assign cnt_nxt_s = cnt_r + 2'd1;
   assign ex_ready  = (state_r == IDLE);
   assign stall_req = ~ex_ready;

   load_extend u_load_extend (
      .funct3   (funct3_r),
      .raw      (raw_s),
      .extended (ext_s)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; a byte completes only when a request is actually out.
   always_comb begin
      state_nxt_s = state_r;
      byte_done_s = 1'b0;
      last_done_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (ex_valid && mem_op_s) begin
               state_nxt_s = ACCESS;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACCESS: begin
            if (mem_req && mem_ack) begin
               byte_done_s = 1'b1;
               if (cnt_r == last_r) begin
                  last_done_s = 1'b1;
                  state_nxt_s = IDLE;
               end else begin
                  state_nxt_s = ACCESS;
               end
            end else begin
               state_nxt_s = ACCESS;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Merge the byte arriving this cycle into the partially assembled result.
   always_comb begin
      raw_s = result_r;
      case (cnt_r)
         2'd0:    raw_s[7:0]   = mem_rdata;
         2'd1:    raw_s[15:8]  = mem_rdata;
         2'd2:    raw_s[23:16] = mem_rdata;
         default: raw_s[31:24] = mem_rdata;
      endcase
   end

   // Operand latch, byte sequencing, memory request and writeback registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_r       <= 32'd0;
         store_data_r <= 32'd0;
         funct3_r     <= 3'd0;
         rd_r         <= 5'd0;
         rd_we_r      <= 1'b0;
         store_r      <= 1'b0;
         last_r       <= 2'd0;
         cnt_r        <= 2'd0;
         result_r     <= 32'd0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= 32'd0;
         mem_wdata    <= 8'd0;
         wb_enable    <= 1'b0;
         wb_addr      <= 5'd0;
         wb_data      <= 32'd0;
      end else begin
         wb_enable <= 1'b0;
         case (state_r)
            IDLE: begin
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
               if (ex_valid && mem_op_s) begin
                  base_r       <= ex_addr;
                  store_data_r <= ex_store_data;
                  funct3_r     <= ex_funct3;
                  rd_r         <= ex_rd;
                  rd_we_r      <= ex_rd_we;
                  // load wins when both kinds are requested
                  store_r      <= ex_store & ~ex_load;
                  last_r       <= last_byte_idx(ex_funct3);
                  cnt_r        <= 2'd0;
                  result_r     <= 32'd0;
               end else if (ex_valid) begin
                  wb_enable <= ex_rd_we && (ex_rd != 5'd0);
                  wb_addr   <= ex_rd;
                  wb_data   <= ex_addr;
               end else begin
                  cnt_r <= cnt_r;
               end
            end
            ACCESS: begin
               if (last_done_s) begin
                  mem_req  <= 1'b0;
                  mem_we   <= 1'b0;
                  cnt_r    <= 2'd0;
                  result_r <= raw_s;
                  if (!store_r) begin
                     wb_enable <= rd_we_r && (rd_r != 5'd0);
                     wb_addr   <= rd_r;
                     wb_data   <= ext_s;
                  end else begin
                     wb_enable <= 1'b0;
                  end
               end else if (byte_done_s) begin
                  cnt_r     <= cnt_nxt_s;
                  result_r  <= raw_s;
                  mem_req   <= 1'b1;
                  mem_we    <= store_r;
                  mem_addr  <= base_r + {30'd0, cnt_nxt_s};
                  mem_wdata <= pick_byte(store_data_r, cnt_nxt_s);
               end else begin
                  // issue or hold the current byte until it is acknowledged
                  mem_req   <= 1'b1;
                  mem_we    <= store_r;
                  mem_addr  <= base_r + {30'd0, cnt_r};
                  mem_wdata <= pick_byte(store_data_r, cnt_r);
               end
            end
            default: begin
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with a writeback scoreboard.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_ready, ex_load, ex_store;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_addr, ex_store_data;
   logic [4:0]  ex_rd;
   logic        ex_rd_we;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;
   logic        mem_ack;
   logic        wb_enable;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        stall_req;

   int n_checks = 0;
   int n_pass   = 0;
   logic [36:0] sb_q[$];

   mem_stage dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_load(ex_load), .ex_store(ex_store), .ex_funct3(ex_funct3),
      .ex_addr(ex_addr), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
      .ex_rd_we(ex_rd_we), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .wb_enable(wb_enable), .wb_addr(wb_addr),
      .wb_data(wb_data), .stall_req(stall_req)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected register value for a load of bytes rb (byte k at rb[8k+:8]).
   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] rb);
      case (f3)
         3'b000:  return {{24{rb[7]}}, rb[7:0]};
         3'b001:  return {{16{rb[15]}}, rb[15:0]};
         3'b100:  return {24'd0, rb[7:0]};
         3'b101:  return {16'd0, rb[15:0]};
         default: return rb;
      endcase
   endfunction

   // Scoreboard: every writeback pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && wb_enable) begin
         chk("wb_expected", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            logic [36:0] e;
            e = sb_q.pop_front();
            chk("wb_addr", 32'(wb_addr), 32'(e[36:32]));
            chk("wb_data", wb_data, e[31:0]);
         end
      end
   end

   task automatic alu_op(input logic [4:0] rd, input logic we, input logic [31:0] val);
      ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b0;
      ex_rd = rd; ex_rd_we = we; ex_addr = val;
      if (we && rd != 5'd0) sb_q.push_back({rd, val});
      tick();
      ex_valid = 1'b0;
      chk("alu_wb_en", 32'(wb_enable), 32'(we && rd != 5'd0));
      chk("alu_ready", 32'(ex_ready), 32'd1);
      tick();
      chk("alu_wb_pulse", 32'(wb_enable), 32'd0);
   endtask

   // Drive one memory op; byte wait_idx waits nwait cycles before its ack.
   task automatic mem_op(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] rd, input logic [31:0] rbytes,
                         input int nbytes, input int wait_idx, input int nwait);
      int k = 0;
      int waits = 0;
      int cyc = 0;
      int req_cycles = 0;
      logic is_store;
      logic [31:0] a_exp;
      logic [31:0] sd;
      is_store = st && !ld;
      sd = sdata;
      ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3;
      ex_addr = addr; ex_store_data = sdata; ex_rd = rd; ex_rd_we = 1'b1;
      if (!is_store && rd != 5'd0) sb_q.push_back({rd, exp_load(f3, rbytes)});
      tick();
      ex_valid = 1'b0;
      while (k < nbytes && cyc < 50) begin
         chk("busy_ready", 32'(ex_ready), 32'd0);
         chk("busy_stall", 32'(stall_req), 32'd1);
         chk("busy_wb", 32'(wb_enable), 32'd0);
         if (mem_req) begin
            req_cycles++;
            a_exp = addr + 32'(k);
            chk("mem_addr", mem_addr, a_exp);
            chk("mem_we", 32'(mem_we), 32'(is_store));
            if (is_store) chk("mem_wdata", 32'(mem_wdata), 32'(sd[8*k +: 8]));
            if (k == wait_idx && waits < nwait) begin
               mem_ack = 1'b0;
               waits++;
            end else begin
               mem_ack = 1'b1;
               mem_rdata = rbytes[8*k +: 8];
               k++;
            end
         end else begin
            mem_ack = 1'b0;
         end
         tick();
         cyc++;
      end
      mem_ack = 1'b0;
      chk("latency", 32'(cyc), 32'(nbytes + nwait + 1));
      chk("req_cycles", 32'(req_cycles), 32'(nbytes + nwait));
      chk("done_ready", 32'(ex_ready), 32'd1);
      chk("done_req", 32'(mem_req), 32'd0);
      chk("done_wb_en", 32'(wb_enable), 32'(!is_store && rd != 5'd0));
      tick();
      chk("done_wb_pulse", 32'(wb_enable), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
      ex_funct3 = 3'd0; ex_addr = 32'd0; ex_store_data = 32'd0;
      ex_rd = 5'd0; ex_rd_we = 1'b0; mem_rdata = 8'd0; mem_ack = 1'b0;
      tick(); tick();
      chk("rst_ready", 32'(ex_ready), 32'd1);
      chk("rst_stall", 32'(stall_req), 32'd0);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wb_en", 32'(wb_enable), 32'd0);
      chk("rst_wb_addr", 32'(wb_addr), 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      rst_n = 1'b1;
      tick();

      // ALU ops: basic, rd==0 and rd_we==0 suppress the pulse
      alu_op(5'd5, 1'b1, 32'h0000_1234);
      chk("alu_hold_addr", 32'(wb_addr), 32'd5);
      chk("alu_hold_data", wb_data, 32'h0000_1234);
      alu_op(5'd0, 1'b1, 32'hDEAD_BEEF);
      alu_op(5'd7, 1'b0, 32'h0000_0077);

      // mem_ack in IDLE is ignored
      mem_ack = 1'b1;
      tick(); tick();
      chk("idle_ack_req", 32'(mem_req), 32'd0);
      chk("idle_ack_ready", 32'(ex_ready), 32'd1);
      chk("idle_ack_wb", 32'(wb_enable), 32'd0);
      mem_ack = 1'b0;

      // LB 0x100 -> 0xFFFFFF80
      mem_op(1'b1, 1'b0, 3'b000, 32'h0000_0100, 32'd0, 5'd3, 32'h0000_0080, 1, 99, 0);
      // misaligned LW with two wait cycles before the third ack
      mem_op(1'b1, 1'b0, 3'b010, 32'h0000_0201, 32'd0, 5'd9, 32'h4433_2211, 4, 2, 2);
      // SH 0x10: bytes 0x34 then 0x12, no writeback
      mem_op(1'b0, 1'b1, 3'b001, 32'h0000_0010, 32'hABCD_1234, 5'd4, 32'd0, 2, 99, 0);
      // LHU to x0: completes without writeback
      mem_op(1'b1, 1'b0, 3'b101, 32'h0000_0040, 32'd0, 5'd0, 32'h0000_9234, 2, 99, 0);
      // LH sign extension, LHU zero extension, LBU
      mem_op(1'b1, 1'b0, 3'b001, 32'h0000_0050, 32'd0, 5'd6, 32'h0000_9234, 2, 0, 1);
      mem_op(1'b1, 1'b0, 3'b101, 32'h0000_0052, 32'd0, 5'd8, 32'h0000_9234, 2, 99, 0);
      mem_op(1'b1, 1'b0, 3'b100, 32'h0000_0060, 32'd0, 5'd10, 32'h0000_00F0, 1, 99, 0);
      // address wrap, unlisted funct3 treated as word, load+store treated as load
      mem_op(1'b1, 1'b0, 3'b111, 32'hFFFF_FFFE, 32'd0, 5'd11, 32'h8765_4321, 4, 99, 0);
      mem_op(1'b1, 1'b1, 3'b000, 32'h0000_0070, 32'h5555_5555, 5'd12, 32'h0000_0011, 1, 99, 0);
      // SW with a wait on byte 0
      mem_op(1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 5'd13, 32'd0, 4, 0, 1);

      // reset during second byte of a LW aborts with no writeback
      ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_funct3 = 3'b010;
      ex_addr = 32'h0000_0400; ex_rd = 5'd14; ex_rd_we = 1'b1;
      tick();
      ex_valid = 1'b0;
      tick();
      chk("abort_req0", 32'(mem_req), 32'd1);
      mem_ack = 1'b1; mem_rdata = 8'hAA;
      tick();
      mem_ack = 1'b0;
      chk("abort_addr1", mem_addr, 32'h0000_0401);
      rst_n = 1'b0;
      #1;
      chk("abort_req_drop", 32'(mem_req), 32'd0);
      chk("abort_ready", 32'(ex_ready), 32'd1);
      chk("abort_wb", 32'(wb_enable), 32'd0);
      tick();
      rst_n = 1'b1;
      mem_ack = 1'b1;
      tick(); tick();
      chk("post_rst_req", 32'(mem_req), 32'd0);
      mem_ack = 1'b0;
      alu_op(5'd21, 1'b1, 32'h0BAD_F00D);

      tick();
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
